// File: rtl/mem_sched_if.sv
// Decoupled valid/ready/data bundle with N parallel lanes, shared by the
// requester-side and memory-side ports of mem_sched.
interface mem_sched_if #(
  parameter int unsigned N     = 1,
  parameter int unsigned Width = 32
);
  logic [N-1:0]            valid;
  logic [N-1:0]            ready;
  logic [N-1:0][Width-1:0] data;

  // Producer drives valid/data; consumer drives ready.
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_sched.sv
// Shares one memory port among CNT requesters, tracks up to DEPTH outstanding requests and
// routes in-order responses back by tag. Define MEM_SCHED_RR_EN for round-robin arbitration.
module mem_sched #(
  parameter int unsigned CNT    = 2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned REQ_W  = 40,
  parameter int unsigned RESP_W = 32,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  mem_sched_if.slave      master_req,
  mem_sched_if.master     master_resp,
  mem_sched_if.master     slave_req,
  mem_sched_if.slave      slave_resp,
  output logic            busy,
  output logic [CntW-1:0] outstanding
);

  localparam int unsigned IdxW = $clog2(CNT);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] tag_q [DEPTH];

  logic [IdxW-1:0] gnt;
  logic            req_any, sreq_valid, push, pop;
  logic            nonempty, resp_ready;
  logic [IdxW-1:0] head;
  logic [CNT-1:0]  mreq_ready, mresp_valid;

`ifdef MEM_SCHED_RR_EN
  localparam logic [IdxW-1:0] IdxLast = IdxW'(CNT - 1);
  // Holds the index where the next search begins, i.e. last_grant + 1 mod CNT.
  logic [IdxW-1:0] rr_q, rr_d;
  int unsigned     rr_cand;
  logic            rr_found;
`endif

  // Arbitration: a held lock overrides any fresh search.
  always_comb begin
    gnt = '0;
`ifdef MEM_SCHED_RR_EN
    rr_cand  = 0;
    rr_found = 1'b0;
`endif
    if (lock_q) begin
      gnt = lock_idx_q;
    end else begin
`ifdef MEM_SCHED_RR_EN
      for (int unsigned off = 0; off < CNT; off++) begin
        rr_cand = int'(rr_q) + off;
        if (rr_cand >= CNT) rr_cand = rr_cand - CNT;
        if (!rr_found && master_req.valid[rr_cand]) begin
          gnt      = IdxW'(rr_cand);
          rr_found = 1'b1;
        end
      end
`else
      for (int i = CNT - 1; i >= 0; i--) begin
        if (master_req.valid[i]) gnt = IdxW'(i);
      end
`endif
    end
  end

  assign req_any    = (|master_req.valid) | lock_q;
  assign sreq_valid = req_any & (cnt_q < DepthC);
  assign push       = sreq_valid & slave_req.ready[0];

  assign slave_req.valid[0] = sreq_valid;
  assign slave_req.data[0]  = master_req.data[gnt];

  always_comb begin
    mreq_ready = '0;
    if (push) mreq_ready[gnt] = 1'b1;
  end
  assign master_req.ready = mreq_ready;

  // Response routing follows the oldest tag; an empty FIFO leaves stray responses untouched.
  assign nonempty   = (cnt_q != '0);
  assign head       = tag_q[rptr_q];
  assign resp_ready = nonempty & master_resp.ready[head];
  assign pop        = slave_resp.valid[0] & resp_ready;

  assign slave_resp.ready[0] = resp_ready;

  always_comb begin
    mresp_valid = '0;
    if (nonempty && slave_resp.valid[0]) mresp_valid[head] = 1'b1;
  end
  assign master_resp.valid = mresp_valid;
  assign master_resp.data  = {CNT{slave_resp.data[0]}};

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      lock_d = 1'b0;
    end else if (sreq_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end

    wptr_d = push ? ((wptr_q == PtrLast) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = pop  ? ((rptr_q == PtrLast) ? '0 : rptr_q + 1'b1) : rptr_q;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

`ifdef MEM_SCHED_RR_EN
    rr_d = rr_q;
    if (push) rr_d = (gnt == IdxLast) ? '0 : gnt + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
`ifdef MEM_SCHED_RR_EN
      rr_q       <= '0;
`endif
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
`ifdef MEM_SCHED_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Tag storage needs no reset: entries are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) tag_q[wptr_q] <= gnt;
  end

  assign busy        = nonempty;
  assign outstanding = cnt_q;

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 Parameter CNT, default 2: number of requesters sharing the memory port; legal range 2..8.
REQ-002 Parameter DEPTH, default 2: maximum outstanding (issued, not yet answered) requests; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 master_req[CNT]  decoupled.in (Data=mreq)  per-requester memory requests; index 0 = data path, index 1 = instruction fetch.
REQ-006 master_resp[CNT]  decoupled.out (Data=mtrans)  per-requester responses.
REQ-007 slave_req  decoupled.out (Data=mreq)  shared memory request port.
REQ-008 slave_resp  decoupled.in (Data=mtrans)  shared memory response port; responses return in issue order.
REQ-009 busy  output  1  high while at least one request is outstanding.
REQ-010 outstanding  output  $clog2(DEPTH+1)  current outstanding count.

Function
REQ-011 Arbitration: fixed priority, lowest asserted master_req[i].valid index wins, unless the macro in REQ-030 is defined.
REQ-012 Grant lock: once slave_req.valid is high for requester i without a fire, the grant stays on i until slave_req fires; higher-priority arrivals do not preempt.
REQ-013 slave_req.valid = (any master_req valid, or lock held) AND outstanding < DEPTH.
REQ-014 slave_req.data = master_req[granted].data, selected combinationally.
REQ-015 master_req[i].ready = slave_req.ready AND slave_req.valid AND granted==i; every other ready is 0.
REQ-016 Issue latency: zero cycles; a request can fire in the same cycle its valid first rises.
REQ-017 Tag FIFO: on slave_req fire, push the granted index into a DEPTH-entry circular FIFO with wrapping read and write pointers.
REQ-018 Response routing: master_resp[head].valid = slave_resp.valid; master_resp[head].data = slave_resp.data; all other master_resp valids are 0.
REQ-019 slave_resp.ready = master_resp[head].ready when the FIFO is non-empty; otherwise 0.
REQ-020 On slave_resp fire, pop the FIFO.
REQ-021 Full: when outstanding == DEPTH, no issue occurs, even if a pop happens in the same cycle.
REQ-022 Simultaneous push and pop when not full: both occur, and outstanding is unchanged.
REQ-023 Empty: slave_resp.valid is ignored; the stray response is not routed and not consumed.
REQ-024 busy = (outstanding != 0); outstanding never exceeds DEPTH and never underflows.

Reset
REQ-025 On rst high at a clock edge: FIFO pointers = 0, outstanding = 0, lock cleared; with the macro defined, the RR pointer = 0.
REQ-026 Reset values: busy = 0, slave_req.valid = 0 (in the cycle after reset), all master_resp valid = 0.
REQ-027 Reset mid-transaction: in-flight tags are discarded; responses arriving after reset follow REQ-023.
REQ-028 Asserting rst takes precedence over any fire in the same cycle.
REQ-029 No asynchronous reset path.

Configuration
REQ-030 Macro MEM_SCHED_RR_EN, when defined: round-robin arbitration; the search starts at last_grant+1 modulo CNT, and last_grant updates on each slave_req fire.
REQ-031 MEM_SCHED_RR_EN, when undefined: fixed priority per REQ-011; no RR pointer register is synthesized.
REQ-032 Grant lock (REQ-012) and all FIFO behaviour are identical in both configurations.

Verification
REQ-033 Both requesters valid, slave_req.ready=1, 4 cycles, macro off -> requester 0 fires all 4 cycles; requester 1 ready=0 throughout.
REQ-034 Same stimulus, MEM_SCHED_RR_EN on -> grants alternate 0,1,0,1.
REQ-035 Requester 1 valid, slave_req.ready=0 for 3 cycles, requester 0 valid from cycle 1 -> grant stays on 1 until it fires, then switches to 0.
REQ-036 DEPTH=2, two issues with no responses -> outstanding=2, slave_req.valid=0; one response -> outstanding=1 on the next cycle, issue resumes.
REQ-037 Issue 1 then 0; responses R1, R2 -> R1 routed only to master_resp[1] and R2 only to master_resp[0]; master_resp[1].ready=0 stalls slave_resp.ready.
REQ-038 rst pulsed with 2 outstanding -> outstanding=0, busy=0 next cycle; a subsequent slave_resp.valid is left unacknowledged.
